// File: rtl/alu_pwr_seq.sv
// alu_pwr_seq: power-sequencing controller for the gated ALU domain.
// Orders power-down as drain -> isolate -> reset -> power off, and power-up
// as power on -> ramp -> release reset -> de-isolate.
// Optional feature macro: ALU_PWR_AUTO_SLEEP_EN (idle auto-sleep, start-in-OFF auto-wake).
module alu_pwr_seq #(
  parameter int unsigned ISO_CYC   = 2,
  parameter int unsigned RAMP_CYC  = 8,
  parameter int unsigned DRAIN_TMO = 64,
  parameter int unsigned IDLE_CYC  = 32
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       sleep_req_i,
  input  logic       wake_req_i,
  input  logic       start_in_i,
  input  logic       alu_busy_i,
  output logic       start_out_o,
  output logic       alu_pwr_en_o,
  output logic       iso_en_o,
  output logic       alu_rst_n_o,
  output logic [2:0] pwr_state_o,
  output logic       done_o,
  output logic       drain_err_o
);

  localparam int unsigned MAX_AB  = (ISO_CYC > RAMP_CYC) ? ISO_CYC : RAMP_CYC;
  localparam int unsigned MAX_CD  = (DRAIN_TMO > IDLE_CYC) ? DRAIN_TMO : IDLE_CYC;
  localparam int unsigned MAX_P   = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
  localparam int unsigned CNT_W   = $clog2(MAX_P + 1);

  typedef enum logic [2:0] {
    S_OFF    = 3'd0,
    S_RAMP   = 3'd1,
    S_RSTREL = 3'd2,
    S_ON     = 3'd3,
    S_DRAIN  = 3'd4,
    S_ISO    = 3'd5
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               pend_q, pend_d;
  logic               err_d;
  logic               pwr_en_d, iso_en_d, rst_n_d, done_d;
  logic               sleep_ev, wake_ev;
  logic               idle_hit, auto_wake;

`ifdef ALU_PWR_AUTO_SLEEP_EN
  logic [CNT_W-1:0]   idle_q, idle_d;

  // Idle detect: ON cycles with no start and no busy; start in OFF wakes the domain.
  always_comb begin
    idle_hit  = (state_q == S_ON) && !start_in_i && !alu_busy_i &&
                (idle_q == CNT_W'(IDLE_CYC - 1));
    auto_wake = (state_q == S_OFF) && start_in_i;
    idle_d    = '0;
    if ((state_q == S_ON) && (state_d == S_ON) && !start_in_i && !alu_busy_i) begin
      idle_d = idle_q + CNT_W'(1);
    end
  end

  // Idle counter register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) idle_q <= '0;
    else       idle_q <= idle_d;
  end
`else
  // Without auto-sleep only explicit requests move the FSM.
  always_comb begin
    idle_hit  = 1'b0;
    auto_wake = 1'b0;
  end
`endif

  // State register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= S_OFF;
    else       state_q <= state_d;
  end

  // Next-state, counter, pending-sleep and drain-error logic
  always_comb begin
    state_d  = state_q;
    cnt_d    = '0;
    pend_d   = pend_q;
    err_d    = drain_err_o;
    sleep_ev = sleep_req_i | idle_hit;
    wake_ev  = wake_req_i | auto_wake;
    unique case (state_q)
      S_OFF: begin
        if (wake_ev) state_d = S_RAMP;
      end
      S_RAMP: begin
        if (cnt_q == CNT_W'(RAMP_CYC - 1)) state_d = S_RSTREL;
        else                               cnt_d   = cnt_q + CNT_W'(1);
      end
      S_RSTREL: begin
        state_d = S_ON;
      end
      S_ON: begin
        if (sleep_ev || pend_q) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (wake_req_i) begin
          state_d = S_ON;
        end else if (!alu_busy_i) begin
          state_d = S_ISO;
        end else if (cnt_q == CNT_W'(DRAIN_TMO - 1)) begin
          state_d = S_ISO;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_ISO: begin
        if (cnt_q == CNT_W'(ISO_CYC - 1)) state_d = S_OFF;
        else                              cnt_d   = cnt_q + CNT_W'(1);
      end
      default: begin
        state_d = S_OFF;
      end
    endcase
    // A sleep request during power-up is remembered; a later wake cancels it.
    if ((state_q == S_RAMP) || (state_q == S_RSTREL)) begin
      if (wake_req_i)       pend_d = 1'b0;
      else if (sleep_req_i) pend_d = 1'b1;
    end else if (state_q == S_ON) begin
      pend_d = 1'b0;
    end
  end

  // Output decode from the upcoming state so outputs come straight from flops
  always_comb begin
    pwr_en_d = 1'b1;
    iso_en_d = 1'b1;
    rst_n_d  = 1'b0;
    unique case (state_d)
      S_OFF:    begin pwr_en_d = 1'b0; iso_en_d = 1'b1; rst_n_d = 1'b0; end
      S_RAMP:   begin pwr_en_d = 1'b1; iso_en_d = 1'b1; rst_n_d = 1'b0; end
      S_RSTREL: begin pwr_en_d = 1'b1; iso_en_d = 1'b1; rst_n_d = 1'b1; end
      S_ON:     begin pwr_en_d = 1'b1; iso_en_d = 1'b0; rst_n_d = 1'b1; end
      S_DRAIN:  begin pwr_en_d = 1'b1; iso_en_d = 1'b0; rst_n_d = 1'b1; end
      S_ISO:    begin pwr_en_d = 1'b1; iso_en_d = 1'b1; rst_n_d = 1'b0; end
      default:  begin pwr_en_d = 1'b0; iso_en_d = 1'b1; rst_n_d = 1'b0; end
    endcase
    // Drain abort back to ON is not a completed transition, so no pulse.
    done_d = ((state_d == S_ON)  && (state_q == S_RSTREL)) ||
             ((state_d == S_OFF) && (state_q == S_ISO));
  end

  // Registered outputs and datapath state
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q        <= '0;
      pend_q       <= 1'b0;
      alu_pwr_en_o <= 1'b0;
      iso_en_o     <= 1'b1;
      alu_rst_n_o  <= 1'b0;
      done_o       <= 1'b0;
      drain_err_o  <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      pend_q       <= pend_d;
      alu_pwr_en_o <= pwr_en_d;
      iso_en_o     <= iso_en_d;
      alu_rst_n_o  <= rst_n_d;
      done_o       <= done_d;
      drain_err_o  <= err_d;
    end
  end

  assign pwr_state_o = state_q;
  // Start gating is combinational so an issuer sees same-cycle acceptance.
  assign start_out_o = start_in_i & (state_q == S_ON) & ~sleep_req_i;

endmodule
